// File: rtl/block_fetch_8x8_pkg.sv
// Shared definitions for the 8x8 tile fetcher: FSM encoding and tile geometry.
package block_fetch_8x8_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WR_HI = 3'd3;
  localparam logic [2:0] ST_WR_LO = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WAIT  = ST_WAIT,
    WR_HI = ST_WR_HI,
    WR_LO = ST_WR_LO,
    FIN   = ST_FIN
  } state_t;

  localparam int TILE_DIM      = 8;
  localparam int WORDS_PER_ROW = 4;

endpackage

// File: rtl/counterr.sv
// Team up-counter: async active-low reset, synchronous clear, count enable, natural wrap.
module counterr #(
  parameter int SIZE = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  output logic [SIZE-1:0] count
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + SIZE'(1);
  end

endmodule

// File: rtl/block_fetch_8x8.sv
// Reads one 8x8 byte tile as 32 16-bit SRAM words and writes it byte-by-byte into the block buffer.
module block_fetch_8x8
  import block_fetch_8x8_pkg::*;
#(
  parameter int AW     = 18,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_stride,
  output logic [AW-1:0] sram_addr,
  output logic          sram_ren,
  input  logic [DW-1:0] sram_rdata,
  output logic          wr_en,
  output logic [2:0]    wr_i,
  output logic [2:0]    wr_j,
  output logic [7:0]    wr_data,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t        state, state_next;
  logic [2:0]    i;
  logic [1:0]    k;
  logic [1:0]    lat;
  logic [AW-1:0] rowbase, stride;
  logic [DW-1:0] word_q;
  logic [2:0]    last_i, last_j;
  logic [7:0]    last_data;
  logic          last_word, adv_k, adv_i;
  logic [2:0]    live_j;
  logic [7:0]    live_data;

  assign last_word = (i == 3'(TILE_DIM - 1)) && (k == 2'(WORDS_PER_ROW - 1));
  assign adv_k     = (state == WR_LO) && !last_word;
  assign adv_i     = adv_k && (k == 2'(WORDS_PER_ROW - 1));

  counterr #(.SIZE(3)) u_cnt_i (
    .clock(clock), .reset(reset), .clr(state == IDLE), .en(adv_i), .count(i)
  );

  counterr #(.SIZE(2)) u_cnt_k (
    .clock(clock), .reset(reset), .clr(state == IDLE), .en(adv_k), .count(k)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = REQ;
      REQ:     state_next = WAIT;
      WAIT:    if (lat == LAT_LAST) state_next = WR_HI;
      WR_HI:   state_next = WR_LO;
      WR_LO:   state_next = last_word ? FIN : REQ;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address walks rowbase+k; stride and base are only ever taken from the latched copies.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rowbase   <= '0;
      stride    <= '0;
      lat       <= '0;
      word_q    <= '0;
      last_i    <= '0;
      last_j    <= '0;
      last_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        rowbase <= base_addr;
        stride  <= row_stride;
      end
      if (adv_i) rowbase <= rowbase + stride;
      if (state == WAIT) begin
        if (lat == LAT_LAST) begin
          lat    <= '0;
          word_q <= sram_rdata;
        end else begin
          lat <= lat + 2'd1;
        end
      end
      if (wr_en) begin
        last_i    <= i;
        last_j    <= live_j;
        last_data <= live_data;
      end
    end
  end

  // Write fields hold the last written values while wr_en is low.
  always_comb begin
    live_j    = {k, state == WR_LO};
    live_data = (state == WR_LO) ? word_q[7:0] : word_q[15:8];
    sram_ren  = (state == REQ);
    sram_addr = rowbase + {{(AW-2){1'b0}}, k};
    wr_en     = (state == WR_HI) || (state == WR_LO);
    wr_i      = wr_en ? i : last_i;
    wr_j      = wr_en ? live_j : last_j;
    wr_data   = wr_en ? live_data : last_data;
    busy      = (state != IDLE) && (state != FIN);
    done      = (state == FIN);
  end

endmodule

// File: tb/tb_block_fetch_8x8.sv
// Scoreboard bench for block_fetch_8x8 with RD_LAT=1 and RD_LAT=3 instances.
module tb_block_fetch_8x8;
  localparam int AW = 18;

  typedef struct packed {
    logic [2:0] i;
    logic [2:0] j;
    logic [7:0] d;
  } wr_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic [AW-1:0] base_addr = '0, row_stride = '0;

  logic [AW-1:0] addr1, addr3;
  logic          ren1, ren3, wr_en1, wr_en3, busy1, busy3, done1, done3;
  logic [15:0]   rdata1 = 16'hDEAD, rdata3 = 16'hDEAD, p1 = 16'hDEAD, p2 = 16'hDEAD;
  logic [2:0]    wi1, wj1, wi3, wj3;
  logic [7:0]    wd1, wd3;

  int  n_chk = 0, n_fail = 0;
  bit  sel = 1'b0;
  int  ren_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int  since_ren = 100;
  bit  prev_wr = 1'b0;
  wr_t exp_wr[$], seen_wr[$];
  logic [AW-1:0] exp_addr[$], seen_addr[$];

  always #5 clock = ~clock;

  block_fetch_8x8 #(.AW(AW), .DW(16), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .base_addr(base_addr), .row_stride(row_stride),
    .sram_addr(addr1), .sram_ren(ren1), .sram_rdata(rdata1), .wr_en(wr_en1), .wr_i(wi1),
    .wr_j(wj1), .wr_data(wd1), .busy(busy1), .done(done1));

  block_fetch_8x8 #(.AW(AW), .DW(16), .RD_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .base_addr(base_addr), .row_stride(row_stride),
    .sram_addr(addr3), .sram_ren(ren3), .sram_rdata(rdata3), .wr_en(wr_en3), .wr_i(wi3),
    .wr_j(wj3), .wr_data(wd3), .busy(busy3), .done(done3));

  // SRAM models: word[a] = a[15:0], garbage outside the valid cycle.
  always @(posedge clock) begin
    rdata1 <= ren1 ? addr1[15:0] : 16'hDEAD;
    p1     <= ren3 ? addr3[15:0] : 16'hDEAD;
    p2     <= p1;
    rdata3 <= p2;
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic push_tile(input logic [AW-1:0] b, input logic [AW-1:0] s);
    logic [AW-1:0] rb, a;
    rb = b;
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < 4; w++) begin
        a = rb + AW'(w);
        exp_addr.push_back(a);
        exp_wr.push_back('{i: 3'(r), j: 3'(2*w),   d: a[15:8]});
        exp_wr.push_back('{i: 3'(r), j: 3'(2*w+1), d: a[7:0]});
      end
      rb = rb + s;
    end
  endtask

  // Monitor: pops the scoreboard whenever the selected DUT issues a read or a write.
  always @(negedge clock) begin
    logic m_ren, m_wr, m_done;
    logic [AW-1:0] m_addr;
    wr_t m_w, e_w;
    logic [AW-1:0] e_a;
    m_ren  = sel ? ren3 : ren1;
    m_wr   = sel ? wr_en3 : wr_en1;
    m_done = sel ? done3 : done1;
    m_addr = sel ? addr3 : addr1;
    m_w    = sel ? '{i: wi3, j: wj3, d: wd3} : '{i: wi1, j: wj1, d: wd1};
    if (reset) begin
      chk("ren_wr_exclusive", 64'(m_ren & m_wr), 64'd0);
      chk("idle_dut_silent", sel ? 64'({ren1, wr_en1, done1}) : 64'({ren3, wr_en3, done3}), 64'd0);
      if (m_ren) begin
        ren_cnt++;
        seen_addr.push_back(m_addr);
        since_ren = 0;
        if (exp_addr.size() == 0) chk("unexpected_ren", 64'(m_addr), 64'h3_FFFF_FFFF);
        else begin
          e_a = exp_addr.pop_front();
          chk("sram_addr", 64'(m_addr), 64'(e_a));
        end
      end else begin
        since_ren++;
      end
      if (m_wr) begin
        wr_cnt++;
        seen_wr.push_back(m_w);
        if (m_w.j[0] == 1'b0) chk("ren_to_hi_gap", 64'(since_ren), sel ? 64'd4 : 64'd2);
        else                  chk("lo_follows_hi", 64'(prev_wr), 64'd1);
        if (exp_wr.size() == 0) chk("unexpected_wr", 64'(m_w), 64'h3FFFF);
        else begin
          e_w = exp_wr.pop_front();
          chk("wr_ijdata", 64'(m_w), 64'(e_w));
        end
      end
      if (m_done) begin
        done_cnt++;
        chk("scoreboard_empty_at_done", 64'(exp_wr.size() + exp_addr.size()), 64'd0);
      end
      prev_wr = m_wr;
    end
  end

  task automatic run_tile(input logic [AW-1:0] b, input logic [AW-1:0] s, input bit hold,
                          input bit use3, input int exp_lat);
    int n;
    sel = use3;
    push_tile(b, s);
    @(posedge clock); #1;
    base_addr = b; row_stride = s;
    if (use3) start3 = 1'b1; else start1 = 1'b1;
    n = 0;
    do begin
      @(posedge clock); n++; #1;
      if (n == 1) begin
        chk("busy_after_start", 64'(use3 ? busy3 : busy1), 64'd1);
        base_addr = ~b; row_stride = s + AW'(7);
        if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      end
    end while (!(use3 ? done3 : done1) && n < 2000);
    chk("done_latency", 64'(n), 64'(exp_lat));
    chk("busy_low_in_fin", 64'(use3 ? busy3 : busy1), 64'd0);
    @(posedge clock); #1;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  initial begin
    int r0, w0, d0, n;
    #1;
    chk("reset_outputs_dut1", {addr1, ren1, wr_en1, wi1, wj1, wd1, busy1, done1}, 64'd0);
    chk("reset_outputs_dut3", {addr3, ren3, wr_en3, wi3, wj3, wd3, busy3, done3}, 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);

    // 1: basic tile
    r0 = ren_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_tile(18'h00100, 18'h00010, 1'b0, 1'b0, 129);
    chk("t1_ren_count", 64'(ren_cnt - r0), 64'd32);
    chk("t1_wr_count", 64'(wr_cnt - w0), 64'd64);
    chk("t1_done_count", 64'(done_cnt - d0), 64'd1);

    // 2: byte order of word 0xA55A
    seen_wr.delete();
    run_tile(18'h0A55A, 18'h00010, 1'b0, 1'b0, 129);
    chk("t2_first_hi", 64'(seen_wr[0]), 64'({3'd0, 3'd0, 8'hA5}));
    chk("t2_first_lo", 64'(seen_wr[1]), 64'({3'd0, 3'd1, 8'h5A}));

    // 3: address wrap
    seen_addr.delete();
    run_tile(18'h3FFFE, 18'h00004, 1'b0, 1'b0, 129);
    chk("t3_addr0", 64'(seen_addr[0]), 64'h3FFFE);
    chk("t3_addr1", 64'(seen_addr[1]), 64'h3FFFF);
    chk("t3_addr2", 64'(seen_addr[2]), 64'h00000);
    chk("t3_addr3", 64'(seen_addr[3]), 64'h00001);
    chk("t3_row1", 64'(seen_addr[4]), 64'h00002);

    // 4: reset during row 3 WAIT
    sel = 1'b0;
    push_tile(18'h00200, 18'h00020);
    @(posedge clock); #1;
    base_addr = 18'h00200; row_stride = 18'h00020; start1 = 1'b1;
    @(posedge clock); #1 start1 = 1'b0;
    n = 0;
    while (!(ren1 && addr1 == 18'h00260) && n < 1000) begin
      @(posedge clock); #1; n++;
    end
    chk("t4_row3_reached", 64'(n < 1000), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("t4_outputs_in_reset", {addr1, ren1, wr_en1, wi1, wj1, wd1, busy1, done1}, 64'd0);
    exp_wr.delete(); exp_addr.delete();
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    repeat (200) @(posedge clock);
    chk("t4_no_wr_after_reset", 64'(wr_cnt - w0), 64'd0);
    chk("t4_no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    run_tile(18'h00300, 18'h00008, 1'b0, 1'b0, 129);

    // 5: start held through fetch and FIN
    d0 = done_cnt; w0 = wr_cnt;
    run_tile(18'h01000, 18'h00100, 1'b1, 1'b0, 129);
    repeat (30) @(posedge clock);
    chk("t5_done_count", 64'(done_cnt - d0), 64'd1);
    chk("t5_wr_count", 64'(wr_cnt - w0), 64'd64);

    // 6: RD_LAT=3 instance
    r0 = ren_cnt; w0 = wr_cnt; d0 = done_cnt;
    run_tile(18'h02345, 18'h00040, 1'b0, 1'b1, 193);
    chk("t6_ren_count", 64'(ren_cnt - r0), 64'd32);
    chk("t6_wr_count", 64'(wr_cnt - w0), 64'd64);
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1);

    repeat (5) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
